// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions for the four-master system bus arbiter:
// owner encodings, master count and active-low enable levels.
package bus_arbiter_pkg;

  localparam int BUS_MASTER_CH = 4;

  typedef enum logic [1:0] {
    BUS_OWNER_MASTER_0 = 2'h0,
    BUS_OWNER_MASTER_1 = 2'h1,
    BUS_OWNER_MASTER_2 = 2'h2,
    BUS_OWNER_MASTER_3 = 2'h3
  } bus_owner_e;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/bus_master_mux.sv
// Pure combinational select of the owning master's address, strobe,
// rw and write data onto the shared bus.
module bus_master_mux
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  bus_owner_e                        sel,
  input  logic [BUS_MASTER_CH*ADDR_W-1:0]   m_addr,
  input  logic [BUS_MASTER_CH-1:0]          m_as_,
  input  logic [BUS_MASTER_CH-1:0]          m_rw,
  input  logic [BUS_MASTER_CH*DATA_W-1:0]   m_wr_data,
  output logic [ADDR_W-1:0]                 bus_addr,
  output logic                              bus_as_,
  output logic                              bus_rw,
  output logic [DATA_W-1:0]                 bus_wr_data
);

  // Route the selected master's signals; non-owner strobes never reach the bus.
  always_comb begin
    bus_addr    = m_addr[int'(sel)*ADDR_W +: ADDR_W];
    bus_as_     = m_as_[sel];
    bus_rw      = m_rw[sel];
    bus_wr_data = m_wr_data[int'(sel)*DATA_W +: DATA_W];
  end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master bus arbiter with parked ownership.
// The owner holds the bus while its request is low; on release the next
// requester is chosen, otherwise the idle owner stays parked.
// Build option ARB_ROUND_ROBIN_EN: when defined, the search starts at
// owner+1 (no starvation); when undefined, fixed priority 0 > 1 > 2 > 3.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int OWNER_W = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BUS_MASTER_CH-1:0]          m_req_,
  input  logic [BUS_MASTER_CH*ADDR_W-1:0]   m_addr,
  input  logic [BUS_MASTER_CH-1:0]          m_as_,
  input  logic [BUS_MASTER_CH-1:0]          m_rw,
  input  logic [BUS_MASTER_CH*DATA_W-1:0]   m_wr_data,
  output logic [BUS_MASTER_CH-1:0]          m_grnt_,
  output logic [ADDR_W-1:0]                 bus_addr,
  output logic                              bus_as_,
  output logic                              bus_rw,
  output logic [DATA_W-1:0]                 bus_wr_data,
  output logic [OWNER_W-1:0]                owner
);

  bus_owner_e                 owner_r;
  bus_owner_e                 owner_nxt_s;
  bus_owner_e                 base_s;
  logic [BUS_MASTER_CH-1:0]   req_act_s;
  logic [BUS_MASTER_CH-1:0]   rot_s;

  // Next-owner selection: requests rotated so bit 0 is the first candidate.
  always_comb begin
    req_act_s = ~m_req_;
`ifdef ARB_ROUND_ROBIN_EN
    base_s = bus_owner_e'(owner_r + 2'd1);
`else
    base_s = BUS_OWNER_MASTER_0;
`endif
    rot_s = 4'({req_act_s, req_act_s} >> base_s);
    owner_nxt_s = owner_r;
    if (m_req_[owner_r] == ENABLE_) begin
      owner_nxt_s = owner_r;
    end else if (rot_s[0]) begin
      owner_nxt_s = base_s;
    end else if (rot_s[1]) begin
      owner_nxt_s = bus_owner_e'(base_s + 2'd1);
    end else if (rot_s[2]) begin
      owner_nxt_s = bus_owner_e'(base_s + 2'd2);
    end else if (rot_s[3]) begin
      owner_nxt_s = bus_owner_e'(base_s + 2'd3);
    end else begin
      owner_nxt_s = owner_r;
    end
  end

  // Owner register, the only state; reset parks the bus on master 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r <= BUS_OWNER_MASTER_0;
    end else begin
      owner_r <= owner_nxt_s;
    end
  end

  // One-cold grant decode so exactly one master is granted at all times.
  always_comb begin
    m_grnt_          = {BUS_MASTER_CH{DISABLE_}};
    m_grnt_[owner_r] = ENABLE_;
  end

  assign owner = owner_r;

  bus_master_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bus_master_mux (
    .sel         (owner_r),
    .m_addr      (m_addr),
    .m_as_       (m_as_),
    .m_rw        (m_rw),
    .m_wr_data   (m_wr_data),
    .bus_addr    (bus_addr),
    .bus_as_     (bus_as_),
    .bus_rw      (bus_rw),
    .bus_wr_data (bus_wr_data)
  );

endmodule
